// File: rtl/mem_stage.sv
// Memory-access stage: issues one 32-bit bus transaction for loads/stores
// with lane steering and load extension, or forwards the ALU result.
package mem_stage_pkg;
  typedef struct packed {
    logic add;
    logic addi;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;
endpackage

// state | meaning
// IDLE  | waiting for enabled
// BUS   | mem_req held, waiting for mem_ready or timeout
// DONE  | completed pulse, flags and result valid
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  instructions instr,
  input  regvpair     register,
  input  logic [31:0] alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        completed,
  output logic [31:0] result,
  output logic        misaligned,
  output logic        access_fault
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic        is_load, is_store, is_mem, mis;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [1:0]  offset;
  logic        size_byte, size_half, sign_ext, load_op;
  logic [31:0] tmo_cnt;
  logic        timeout_hit;
  logic [31:0] rd_shift, load_val;
  logic        start_alu, start_mis, start_bus, bus_ok, bus_tmo;
  logic        unused_bits;

  assign unused_bits = ^{register.rs1, instr.add, instr.addi};

  assign is_load  = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
  assign is_store = instr.sb | instr.sh | instr.sw;
  assign is_mem   = is_load | is_store;
  assign mis      = ((instr.lh | instr.lhu | instr.sh) & alu_result[0]) |
                    ((instr.lw | instr.sw) & (alu_result[1:0] != 2'b00));

  assign mem_req   = (state == BUS);
  assign completed = (state == DONE);

  // A count of TIMEOUT_CYCLES-1 plus the current idle cycle means the limit is reached.
  assign timeout_hit = (TMO != 32'd0) && ((tmo_cnt + 32'd1) == TMO);

  always_comb begin
    wstrb_in = 4'b0000;
    wdata_in = register.rs2;
    if (instr.sb) begin
      wstrb_in = 4'b0001 << alu_result[1:0];
      wdata_in = {4{register.rs2[7:0]}};
    end else if (instr.sh) begin
      wstrb_in = 4'b0011 << alu_result[1:0];
      wdata_in = {2{register.rs2[15:0]}};
    end else if (instr.sw) begin
      wstrb_in = 4'b1111;
    end
  end

  always_comb begin
    rd_shift = mem_rdata >> {offset, 3'b000};
    if (size_byte)
      load_val = sign_ext ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
    else if (size_half)
      load_val = sign_ext ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
    else
      load_val = mem_rdata;
  end

  always_comb begin
    state_next = state;
    start_alu  = 1'b0;
    start_mis  = 1'b0;
    start_bus  = 1'b0;
    bus_ok     = 1'b0;
    bus_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (enabled) begin
          if (!is_mem) begin
            start_alu  = 1'b1;
            state_next = DONE;
          end else if (mis) begin
            start_mis  = 1'b1;
            state_next = DONE;
          end else begin
            start_bus  = 1'b1;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          bus_ok     = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          bus_tmo    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wstrb    <= 4'd0;
      mem_wdata    <= 32'd0;
      result       <= 32'd0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      tmo_cnt      <= 32'd0;
      offset       <= 2'd0;
      size_byte    <= 1'b0;
      size_half    <= 1'b0;
      sign_ext     <= 1'b0;
      load_op      <= 1'b0;
    end else begin
      if (start_alu | start_mis | start_bus) begin
        misaligned   <= start_mis;
        access_fault <= 1'b0;
        tmo_cnt      <= 32'd0;
      end
      if (start_alu)
        result <= alu_result;
      if (start_bus) begin
        mem_addr  <= {alu_result[31:2], 2'b00};
        mem_we    <= is_store;
        mem_wstrb <= wstrb_in;
        mem_wdata <= wdata_in;
        offset    <= alu_result[1:0];
        size_byte <= instr.lb | instr.lbu | instr.sb;
        size_half <= instr.lh | instr.lhu | instr.sh;
        sign_ext  <= instr.lb | instr.lh;
        load_op   <= is_load;
      end
      if ((state == BUS) && !mem_ready)
        tmo_cnt <= tmo_cnt + 32'd1;
      if (bus_ok)
        result <= load_op ? load_val : 32'd0;
      if (bus_tmo)
        access_fault <= 1'b1;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the decoded instruction, the register value pair, and the ALU result (effective address for loads/stores, final value otherwise).
- Loads/stores: performs one 32-bit bus transaction with byte-lane steering, store-data replication and load sign/zero extension.
- All other instructions: forwards the ALU result to writeback.
- Flags misaligned accesses and bus timeouts instead of issuing or hanging.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles mem_req may stay high without mem_ready before an access fault; 0 disables the timeout.

Ports:
clk  in  1  sole clock; all state updates on rising edge.
rst  in  1  reset; synchronous and active-high.
enabled  in  1  one-cycle start strobe from the ALU stage; sampled only in IDLE.
instr  in  instructions  decoded instruction flags (lb/lh/lw/lbu/lhu/sb/sh/sw used here).
register  in  regvpair  operands; register.rs2 is store data.
alu_result  in  32  effective address or final result.
mem_req  out  1  bus request.
mem_we  out  1  1 = write.
mem_addr  out  32  word address; {alu_result[31:2], 2'b00}.
mem_wstrb  out  4  byte-lane write enables.
mem_wdata  out  32  lane-replicated store data.
mem_ready  in  1  bus completion; read data valid in the same cycle.
mem_rdata  in  32  read word.
completed  out  1  one-cycle done pulse.
result  out  32  writeback value, held until next completion.
misaligned  out  1  valid with completed; access not issued.
access_fault  out  1  valid with completed; timeout expired.

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, completed, misaligned, access_fault = 0; mem_addr, mem_wstrb, mem_wdata, result = 0; timeout counter = 0.
- Reset mid-transaction aborts it. mem_req is low from the cycle after rst is sampled high. A late mem_ready is ignored.
- States: IDLE, BUS, DONE.
- IDLE, enabled=1, non-memory instruction:
  - result <= alu_result; go to DONE.
  - completed pulses in the cycle after enabled (latency 1).
- IDLE, enabled=1, memory instruction:
  - Misaligned if (lh/lhu/sh and addr[0]) or (lw/sw and addr[1:0]!=0). Then: no request, misaligned=1, result unchanged, go to DONE.
  - Otherwise: latch mem_addr, mem_we, mem_wstrb, mem_wdata, offset and size/sign; assert mem_req; go to BUS.
- Store lanes:
  - sb: wstrb = 1<<addr[1:0]; wdata = rs2[7:0] replicated x4.
  - sh: wstrb = 4'b0011<<addr[1:0]; wdata = rs2[15:0] replicated x2.
  - sw: wstrb = 4'b1111; wdata = rs2.
  - Loads: wstrb = 4'b0000.
- BUS:
  - All bus outputs stay stable while mem_req=1.
  - mem_ready sampled 1 at an edge: mem_req <= 0, capture data, go to DONE.
  - Loads: select byte/half at offset. lb/lh sign-extend; lbu/lhu zero-extend; lw takes the whole word.
  - Stores: result <= 0.
  - Timeout counter increments each BUS cycle without mem_ready. When it reaches TIMEOUT_CYCLES (if nonzero): drop mem_req, access_fault=1, result unchanged, go to DONE.
  - mem_ready and the timeout in the same cycle: mem_ready wins.
- DONE:
  - completed=1 for exactly one cycle, then IDLE.
  - misaligned and access_fault are cleared on the next start.
  - enabled asserted in DONE or BUS is ignored; the upstream stage must wait for completed.
- Minimum memory latency: enabled at cycle 0; mem_req high in cycle 1; mem_ready in cycle 1 gives completed in cycle 2.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- addi: alu_result=32'h0000_0055, enabled 1 cycle -> completed pulse next cycle, result=32'h55, mem_req never high.
- lb at addr 32'h103, mem_rdata=32'h80AA_BBCC, mem_ready 3 cycles after request -> mem_addr=32'h100, wstrb=0, result=32'hFFFF_FF80. Repeat with lbu -> result=32'h0000_0080.
- sh at addr 32'h202, rs2=32'h1234_ABCD -> mem_we=1, wstrb=4'b1100, wdata=32'hABCD_ABCD; completed one cycle after mem_ready.
- lw at addr 32'h105 -> no mem_req, completed next cycle with misaligned=1, result unchanged.
- TIMEOUT_CYCLES=4, sw with mem_ready held 0 -> mem_req drops after 4 cycles, completed with access_fault=1. mem_ready in the 4th cycle instead -> normal completion, access_fault=0.
- rst pulsed while in BUS -> mem_req low next cycle, no completed pulse. A following enabled lw completes normally.
